// File: rtl/axi_full_rd_m_if.sv
// Cache-side and AXI4 read-channel signals for the cache-refill read master.
//   master modport : the refill engine (drives req_ready, line_*, AR outputs, rready)
//   slave  modport : the environment (cache + AXI memory slave)
// Cache side : req_valid/req_addr/req_ready, line_valid/line_data/line_err/line_ready
// AXI AR     : araddr, arvalid, arburst, arlen, arsize, arready
// AXI R      : rdata, rresp, rvalid, rlast, rready
interface axi_full_rd_m_if #(
  parameter int LINE_BEATS = 4
) ();
  logic                    req_valid;
  logic [31:0]             req_addr;
  logic                    req_ready;
  logic                    line_valid;
  logic [64*LINE_BEATS-1:0] line_data;
  logic                    line_err;
  logic                    line_ready;
  logic [31:0]             araddr;
  logic                    arvalid;
  logic [1:0]              arburst;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic                    arready;
  logic [63:0]             rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rlast;
  logic                    rready;

  modport master (
    input  req_valid, req_addr, line_ready, arready, rdata, rresp, rvalid, rlast,
    output req_ready, line_valid, line_data, line_err,
           araddr, arvalid, arburst, arlen, arsize, rready
  );

  modport slave (
    output req_valid, req_addr, line_ready, arready, rdata, rresp, rvalid, rlast,
    input  req_ready, line_valid, line_data, line_err,
           araddr, arvalid, arburst, arlen, arsize, rready
  );
endinterface

// File: rtl/axi_full_rd_m.sv
// Cache-refill AXI4 read master. Takes one miss request, issues a single INCR
// burst of LINE_BEATS 64-bit beats for the line-aligned address, assembles the
// line and returns it with an error flag over a valid/ready handshake.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : axi_full_rd_m_if.master (cache request/line + AXI AR/R channels)
module axi_full_rd_m #(
  parameter int LINE_BEATS = 4
) (
  input  logic            clk,
  input  logic            rst,
  axi_full_rd_m_if.master bus
);
  localparam int LINE_BYTES = LINE_BEATS * 8;
  localparam int CW         = $clog2(LINE_BEATS) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [31:0]               r_araddr;
  logic [CW-1:0]             r_cnt;
  logic                      r_err;
  logic [64*LINE_BEATS-1:0]  r_data;
  logic                      w_beat;
  logic                      w_final;

  assign w_beat  = (r_state == R) && bus.rvalid;
  // The beat counter, not rlast, decides when the burst is complete.
  assign w_final = w_beat && (r_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.req_valid)  w_next = AR;
      AR:      if (bus.arready)    w_next = R;
      R:       if (w_final)        w_next = DONE;
      DONE:    if (bus.line_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_araddr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_data   <= '0;
    end else begin
      if (r_state == IDLE && bus.req_valid) begin
        r_araddr <= bus.req_addr & ~32'(LINE_BYTES - 1);
        r_cnt    <= '0;
        r_err    <= 1'b0;
      end
      if (w_beat) begin
        for (int unsigned i = 0; i < LINE_BEATS; i++) begin
          if (r_cnt == CW'(i)) r_data[64*i +: 64] <= bus.rdata;
        end
        // Error on a bad response or an rlast that disagrees with the count.
        if ((bus.rresp != 2'b00) || (bus.rlast != (r_cnt == LAST_BEAT)))
          r_err <= 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.arvalid    = (r_state == AR);
  assign bus.rready     = (r_state == R);
  assign bus.line_valid = (r_state == DONE);
  assign bus.line_err   = r_err;
  assign bus.line_data  = r_data;
  assign bus.araddr     = r_araddr;
  assign bus.arburst    = 2'b01;
  assign bus.arlen      = 8'(LINE_BEATS - 1);
  assign bus.arsize     = 3'd3;
endmodule

// File: tb/tb_axi_full_rd_m.sv
module tb_axi_full_rd_m;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_full_rd_m_if #(.LINE_BEATS(LB)) bus ();
  axi_full_rd_m_if #(.LINE_BEATS(1))  bus1 ();

  axi_full_rd_m #(.LINE_BEATS(LB)) dut  (.clk(clk), .rst(rst), .bus(bus));
  axi_full_rd_m #(.LINE_BEATS(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: line base is the address rounded down to a multiple of the line size.
  function automatic logic [31:0] line_base(input logic [31:0] a, input int lb);
    return a - (a % 32'(lb * 8));
  endfunction

  // One complete refill on the LB-beat instance. Called right after a negedge;
  // inputs are driven at negedges, outputs sampled at negedges.
  task automatic refill(input logic [31:0] addr, input int ar_wait, input int gap_at,
                        input int gap_len, input int bad_beat, input int rlast_beat,
                        input int lr_wait, input bit hold_req, input bit chk_lat);
    logic [1023:0] exp_line;
    logic [31:0]   exp_addr;
    logic [63:0]   d;
    bit            exp_err;
    int            lat;
    exp_addr = line_base(addr, LB);
    exp_line = '0;
    exp_err  = 1'b0;
    lat      = 0;
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    @(negedge clk); lat++;
    if (!hold_req) begin
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
    end
    chk("arvalid_on", bus.arvalid, 1);
    chk("araddr", bus.araddr, exp_addr);
    chk("req_ready_busy", bus.req_ready, 0);
    chk("arlen", bus.arlen, LB - 1);
    chk("arburst", bus.arburst, 1);
    chk("arsize", bus.arsize, 3);
    chk("rready_ar", bus.rready, 0);
    repeat (ar_wait) begin
      @(negedge clk); lat++;
      chk("arvalid_hold", bus.arvalid, 1);
      chk("araddr_hold", bus.araddr, exp_addr);
    end
    bus.arready = 1'b1;
    @(negedge clk); lat++;
    bus.arready = 1'b0;
    chk("arvalid_off", bus.arvalid, 0);
    chk("rready_on", bus.rready, 1);
    for (int i = 0; i < LB; i++) begin
      if (i == gap_at) begin
        repeat (gap_len) begin
          bus.rvalid = 1'b0;
          bus.rdata  = {$urandom, $urandom};
          bus.rlast  = 1'b1;
          @(negedge clk); lat++;
          chk("rready_gap", bus.rready, 1);
          chk("line_valid_gap", bus.line_valid, 0);
        end
      end
      d = {$urandom, $urandom};
      bus.rvalid = 1'b1;
      bus.rdata  = d;
      bus.rresp  = (i == bad_beat) ? 2'b10 : 2'b00;
      bus.rlast  = (i == rlast_beat);
      exp_line[64*i +: 64] = d;
      if (i == bad_beat) exp_err = 1'b1;
      if ((i == rlast_beat) != (i == LB - 1)) exp_err = 1'b1;
      @(negedge clk); lat++;
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      bus.rresp  = 2'b00;
      if (i < LB - 1) chk("line_valid_early", bus.line_valid, 0);
    end
    chk("line_valid", bus.line_valid, 1);
    chk("rready_done", bus.rready, 0);
    chk("line_data", bus.line_data, exp_line);
    chk("line_err", bus.line_err, exp_err);
    if (chk_lat) chk("latency", lat, LB + 2);
    // Stray R beats while waiting for the cache must not be captured.
    repeat (lr_wait) begin
      bus.rvalid = 1'b1;
      bus.rdata  = {$urandom, $urandom};
      @(negedge clk);
      chk("line_valid_hold", bus.line_valid, 1);
      chk("line_data_hold", bus.line_data, exp_line);
      chk("line_err_hold", bus.line_err, exp_err);
    end
    bus.rvalid     = 1'b0;
    bus.line_ready = 1'b1;
    @(negedge clk);
    bus.line_ready = 1'b0;
    chk("line_valid_off", bus.line_valid, 0);
    chk("req_ready_back", bus.req_ready, 1);
    chk("no_overlap_ar", bus.arvalid, 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [63:0] d;
    {bus.req_valid, bus.req_addr, bus.line_ready, bus.arready,
     bus.rdata, bus.rresp, bus.rvalid, bus.rlast} = '0;
    {bus1.req_valid, bus1.req_addr, bus1.line_ready, bus1.arready,
     bus1.rdata, bus1.rresp, bus1.rvalid, bus1.rlast} = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_line_valid", bus.line_valid, 0);
    chk("rst_line_err", bus.line_err, 0);
    chk("rst_line_data", bus.line_data, 0);
    chk("rst_araddr", bus.araddr, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("req_ready_after_rst", bus.req_ready, 1);

    // Basic refill with minimum latency
    refill(32'h8000_0014, 0, -1, 0, -1, LB - 1, 0, 1'b0, 1'b1);
    // Backpressure on AR, R gap between beats 1 and 2, slow line consumer
    refill($urandom, 5, 2, 3, -1, LB - 1, 4, 1'b0, 1'b0);
    // Error response on beat 2
    refill($urandom, 0, -1, 0, 2, LB - 1, 0, 1'b0, 1'b0);
    // Early rlast on beat 1, then missing rlast on final beat
    refill($urandom, 0, -1, 0, -1, 1, 0, 1'b0, 1'b0);
    refill($urandom, 0, -1, 0, -1, -1, 0, 1'b0, 1'b0);

    // Reset mid-burst: two beats in, third beat offered at the reset edge
    bus.req_valid = 1'b1;
    bus.req_addr  = $urandom;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.arready   = 1'b1;
    @(negedge clk);
    bus.arready   = 1'b0;
    repeat (2) begin
      bus.rvalid = 1'b1;
      bus.rdata  = {$urandom, $urandom};
      @(negedge clk);
    end
    bus.rdata = {$urandom, $urandom};
    rst = 1'b0;
    @(negedge clk);
    bus.rvalid = 1'b0;
    chk("midrst_rready", bus.rready, 0);
    chk("midrst_line_valid", bus.line_valid, 0);
    chk("midrst_line_data", bus.line_data, 0);
    chk("midrst_araddr", bus.araddr, 0);
    chk("midrst_arvalid", bus.arvalid, 0);
    chk("midrst_req_ready", bus.req_ready, 1);
    rst = 1'b1;
    @(negedge clk);
    refill(32'h8000_0040, 0, -1, 0, -1, LB - 1, 0, 1'b0, 1'b1);

    // Back-to-back with req_valid held high across the line handshake
    refill($urandom, 0, -1, 0, -1, LB - 1, 1, 1'b1, 1'b1);
    refill($urandom, 0, -1, 0, -1, LB - 1, 0, 1'b1, 1'b1);
    bus.req_valid = 1'b0;

    // Randomised refills
    for (int k = 0; k < 8; k++) begin
      refill($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, LB - 1)),
             int'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, LB - 1)) : -1,
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LB - 1)) : LB - 1,
             int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    // Single-beat line build
    for (int k = 0; k < 2; k++) begin
      a = $urandom;
      d = {$urandom, $urandom};
      chk("lb1_req_ready", bus1.req_ready, 1);
      bus1.req_valid = 1'b1;
      bus1.req_addr  = a;
      @(negedge clk);
      bus1.req_valid = 1'b0;
      chk("lb1_arvalid", bus1.arvalid, 1);
      chk("lb1_araddr", bus1.araddr, line_base(a, 1));
      chk("lb1_arlen", bus1.arlen, 0);
      bus1.arready = 1'b1;
      @(negedge clk);
      bus1.arready = 1'b0;
      chk("lb1_rready", bus1.rready, 1);
      bus1.rvalid = 1'b1;
      bus1.rdata  = d;
      bus1.rlast  = (k == 0);
      @(negedge clk);
      bus1.rvalid = 1'b0;
      bus1.rlast  = 1'b0;
      chk("lb1_line_valid", bus1.line_valid, 1);
      chk("lb1_line_data", bus1.line_data, d);
      chk("lb1_line_err", bus1.line_err, (k != 0));
      bus1.line_ready = 1'b1;
      @(negedge clk);
      bus1.line_ready = 1'b0;
      chk("lb1_line_valid_off", bus1.line_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/axi_full_rd_m.md
# axi_full_rd_m

Cache-refill AXI4 read master, directly upstream of the AXI-full memory slave. Accepts a single miss request from the cache and issues one INCR burst of 64-bit beats for the aligned line. Collects the returned beats into a line buffer and hands the complete line, with an error flag, back to the cache over a valid/ready handshake. Read-only: no AW/W/B channels.

## Interface
- LINE_BEATS, 4, beats per cache line; power of two, 1..16; line size = LINE_BEATS*8 bytes
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the clock edge)
- req_valid  in  1  cache miss request
- req_addr  in  32  miss byte address; any alignment
- req_ready  out  1  request accepted when req_valid&req_ready
- line_valid  out  1  refilled line available
- line_data  out  64*LINE_BEATS  line; beat i at bits [64*i+63:64*i]
- line_err  out  1  refill error, valid with line_valid
- line_ready  in  1  cache consumes line
- araddr  out  32  burst start address, line-aligned
- arvalid  out  1  AR valid
- arburst  out  2  constant 2'b01 (INCR)
- arlen  out  8  constant LINE_BEATS-1
- arsize  out  3  constant 3'd3 (8 bytes)
- arready  in  1  AR ready
- rdata  in  64  read data
- rresp  in  2  read response; nonzero = error
- rvalid  in  1  R valid
- rlast  in  1  last beat of burst
- rready  out  1  R ready

## Operation
- States: IDLE, AR, R, DONE (registered).
- IDLE: req_ready=1. On req_valid: araddr <= req_addr with low log2(LINE_BEATS*8) bits cleared; beat_cnt <= 0; err <= 0; -> AR.
- AR: arvalid=1, araddr stable. On arready: -> R. arvalid must not drop before handshake.
- R: rready=1. Each rvalid beat: line_data[beat_cnt] <= rdata; err |= (rresp!=2'b00); err |= (rlast != (beat_cnt==LINE_BEATS-1)); beat_cnt++. Beat with beat_cnt==LINE_BEATS-1 is final -> DONE. Counter, not rlast, terminates the burst; a late or early rlast only sets err.
- DONE: line_valid=1, line_err=err; line_data and line_err stable. On line_ready: -> IDLE.
- req_ready=0 in AR, R, DONE; requests arriving then wait (no queueing).
- rready=0 outside R; line_ready ignored outside DONE; arready ignored outside AR.
- beat_cnt width log2(LINE_BEATS)+1; never wraps within a burst.
- LINE_BEATS=1: single beat, arlen=0, rlast required on beat 0.

## Timing
- Reset values: state IDLE, arvalid 0, rready 0, line_valid 0, line_err 0, line_data 0, araddr 0, beat_cnt 0. req_ready=1 first cycle after reset release.
- Request accepted in cycle t -> arvalid=1 in t+1.
- AR handshake in cycle a -> rready=1 from a+1.
- Final beat in cycle m -> line_valid=1 in m+1.
- Minimum request-to-line_valid latency: LINE_BEATS+2 cycles (arready and rvalid tied high).
- line_ready handshake in cycle d -> req_ready=1 in d+1; no same-cycle line-out/request-in overlap.
- rvalid gaps: beats accepted only when rvalid=1; any number of idle cycles allowed.
- Reset mid-operation (any state): next edge forces IDLE and all reset values; in-flight beats dropped (rready=0), partial line discarded.
- req_valid and line_ready both high in DONE: only line handshake completes; request accepted next cycle.

## Test plan
- Basic refill, LINE_BEATS=4: req_addr=0x8000_0014, arready/rvalid always 1, rdata=0x11..,0x22..,0x33..,0x44.., rlast on beat 3 -> araddr=0x8000_0000, arlen=3, arburst=1, arsize=3; line_valid at cycle 6, line_data beats in order, line_err=0.
- Backpressure: arready held 0 for 5 cycles, rvalid gap of 3 cycles between beats 1 and 2, line_ready held 0 for 4 cycles -> arvalid/araddr stable, no extra beats captured, line_data stable until handshake.
- Error response: rresp=2'b10 on beat 2 only -> full line captured, line_err=1.
- rlast protocol: rlast on beat 1 (early) -> refill continues to beat 3, line_err=1; rlast absent on beat 3 -> DONE reached, line_err=1.
- Reset mid-burst: rst=0 after beat 1 -> next cycle IDLE, rready=0, line_valid=0, line_data=0; new request to 0x8000_0040 refills cleanly with line_err=0.
- Back-to-back: req_valid held high throughout -> second request accepted exactly one cycle after first line_ready handshake; LINE_BEATS=1 build: arlen=0, one-beat line.
